fetch_stage: RTL and testbench

Instruction-fetch stage that sits directly upstream of the decode stage. It owns the program counter and issues one-word requests to the testbench-side instruction memory over a req/ready handshake. It presents `pipe_pc`, `pipe_pc4` and `pipe_data` to decode, and takes `control_j`/`pc_j` back from decode as the redirect path. Redirects squash the slot with a NOP, and stalls are absorbed by a one-entry skid buffer.

---
 rtl/fetch_stage_pkg.sv | 25 ++
 rtl/fetch_skid.sv | 52 +++++
 rtl/fetch_stage.sv | 216 +++++++++++++++++++++
 tb/tb_fetch_stage.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: state encoding,
// instruction width, the NOP word used for flushed/bubble slots and the
// default reset PC.
package fetch_stage_pkg;

    localparam int unsigned INST_W = 32;

    localparam logic [INST_W-1:0] NOP_INST         = 32'h0000_0013;
    localparam logic [INST_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [INST_W-1:0] PC_STEP          = 32'd4;
    localparam logic [INST_W-1:0] ALIGN_MASK       = 32'h0000_0003;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SKID,
        DISCARD
    } fetch_state_e;

    // Redirect targets are always word aligned; low two bits are cleared.
    function automatic logic [INST_W-1:0] align_pc(input logic [INST_W-1:0] addr);
        return addr & ~ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer holding a fetched instruction and its PC while
// decode is stalled. Load takes priority over drop.
module fetch_skid
    import fetch_stage_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic              drop,
    input  logic [INST_W-1:0] load_pc,
    input  logic [INST_W-1:0] load_data,
    output logic [INST_W-1:0] skid_pc,
    output logic [INST_W-1:0] skid_data,
    output logic              empty
);

    logic              valid_q, valid_d;
    logic [INST_W-1:0] pc_q, pc_d;
    logic [INST_W-1:0] data_q, data_d;

    // Capture a new entry on load, release it on drop.
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            pc_d    = load_pc;
            data_d  = load_data;
        end else if (drop) begin
            valid_d = 1'b0;
        end
    end

    // Entry registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            data_q  <= data_d;
        end
    end

    assign skid_pc   = pc_q;
    assign skid_data = data_q;
    assign empty     = ~valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one-word requests over a
// req/ready handshake, feeds decode through pipe registers, accepts
// redirects from decode and absorbs stalls with a one-entry skid buffer.
// Optional macro FETCH_PERF_EN adds fetch/flush performance counters.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [INST_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              stall,
    input  logic              control_j,
    input  logic [INST_W-1:0] pc_j,
    output logic              imem_req,
    output logic [INST_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [INST_W-1:0] imem_data,
    output logic [INST_W-1:0] pipe_pc,
    output logic [INST_W-1:0] pipe_pc4,
    output logic [INST_W-1:0] pipe_data,
    output logic              pipe_valid
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_flush_cnt
`endif
);

    fetch_state_e      state_q, state_d;
    logic [INST_W-1:0] pc_q, pc_d;
    logic [INST_W-1:0] req_addr_q, req_addr_d;
    logic              pending_q, pending_d;
    logic [INST_W-1:0] pipe_pc_q, pipe_pc_d;
    logic [INST_W-1:0] pipe_pc4_q, pipe_pc4_d;
    logic [INST_W-1:0] pipe_data_q, pipe_data_d;
    logic              pipe_valid_q, pipe_valid_d;

    logic              skid_load;
    logic              skid_drop;
    logic [INST_W-1:0] skid_pc;
    logic [INST_W-1:0] skid_data;
    logic              skid_empty;
    logic              squash;
    logic              valid_load;
    logic [INST_W-1:0] redirect_pc;

    assign redirect_pc = align_pc(pc_j);

    fetch_skid u_skid (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (skid_load),
        .drop      (skid_drop),
        .load_pc   (imem_addr),
        .load_data (imem_data),
        .skid_pc   (skid_pc),
        .skid_data (skid_data),
        .empty     (skid_empty)
    );

    // FSM next state, memory request, PC update and pipe-slot contents.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_addr_d   = req_addr_q;
        pipe_pc_d    = pipe_pc_q;
        pipe_pc4_d   = pipe_pc4_q;
        pipe_data_d  = pipe_data_q;
        pipe_valid_d = pipe_valid_q;
        imem_req     = 1'b0;
        imem_addr    = pending_q ? req_addr_q : pc_q;
        skid_load    = 1'b0;
        skid_drop    = 1'b0;
        squash       = 1'b0;
        valid_load   = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end

            FETCH: begin
                imem_req = pending_q | ~stall;
                if (imem_req && imem_ready) begin
                    if (control_j) begin
                        pc_d   = redirect_pc;
                        squash = 1'b1;
                    end else if (stall) begin
                        skid_load = 1'b1;
                        pc_d      = imem_addr + PC_STEP;
                        state_d   = SKID;
                    end else begin
                        pipe_pc_d   = imem_addr;
                        pipe_pc4_d  = imem_addr + PC_STEP;
                        pipe_data_d = imem_data;
                        valid_load  = 1'b1;
                        pc_d        = imem_addr + PC_STEP;
                    end
                end else if (control_j) begin
                    pc_d   = redirect_pc;
                    squash = 1'b1;
                    if (imem_req) begin
                        state_d = DISCARD;
                    end
                end else if (!stall) begin
                    squash = 1'b1;
                end
            end

            SKID: begin
                if (control_j) begin
                    skid_drop = 1'b1;
                    pc_d      = redirect_pc;
                    squash    = 1'b1;
                    state_d   = FETCH;
                end else if (!stall) begin
                    skid_drop = 1'b1;
                    state_d   = FETCH;
                    if (!skid_empty) begin
                        pipe_pc_d   = skid_pc;
                        pipe_pc4_d  = skid_pc + PC_STEP;
                        pipe_data_d = skid_data;
                        valid_load  = 1'b1;
                    end else begin
                        squash = 1'b1;
                    end
                end
            end

            DISCARD: begin
                imem_req = 1'b1;
                if (control_j) begin
                    pc_d = redirect_pc;
                end
                if (imem_ready) begin
                    state_d = FETCH;
                end
                if (!stall) begin
                    squash = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (valid_load) begin
            pipe_valid_d = 1'b1;
        end
        if (squash) begin
            pipe_data_d  = NOP_INST;
            pipe_valid_d = 1'b0;
        end

        pending_d = imem_req & ~imem_ready;
        if (imem_req) begin
            req_addr_d = imem_addr;
        end
    end

    // State, PC, request tracking and pipe registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            req_addr_q   <= RESET_PC;
            pending_q    <= 1'b0;
            pipe_pc_q    <= '0;
            pipe_pc4_q   <= '0;
            pipe_data_q  <= NOP_INST;
            pipe_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_addr_q   <= req_addr_d;
            pending_q    <= pending_d;
            pipe_pc_q    <= pipe_pc_d;
            pipe_pc4_q   <= pipe_pc4_d;
            pipe_data_q  <= pipe_data_d;
            pipe_valid_q <= pipe_valid_d;
        end
    end

    assign pipe_pc    = pipe_pc_q;
    assign pipe_pc4   = pipe_pc4_q;
    assign pipe_data  = pipe_data_q;
    assign pipe_valid = pipe_valid_q;

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Count valid instructions delivered to decode and accepted redirects.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q + (valid_load ? 32'd1 : 32'd0);
        flush_cnt_d = flush_cnt_q + ((control_j && (state_q != IDLE)) ? 32'd1 : 32'd0);
    end

    // Counter registers, wrapping naturally at 2^32.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by
// randomized stall/redirect/memory-latency traffic, compared every cycle
// against a transaction-level reference model.
module tb_fetch_stage;

    localparam logic [31:0] TB_RESET_PC = 32'hFFFF_FFF8;
    localparam logic [31:0] DATA_KEY    = 32'hA5A5_0000;
    localparam logic [31:0] NOP_WORD    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        stall = 1'b0;
    logic        control_j = 1'b0;
    logic [31:0] pc_j = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_data = '0;
    logic [31:0] pipe_pc;
    logic [31:0] pipe_pc4;
    logic [31:0] pipe_data;
    logic        pipe_valid;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    int cmp_count  = 0;
    int mism_count = 0;

    // Reference model: next PC, the request in flight (and whether its data
    // is to be thrown away), instructions parked while decode is stalled,
    // and the slot decode currently sees.
    bit          m_idle;
    logic [31:0] m_pc;
    bit          m_fly;
    bit          m_dead;
    logic [31:0] m_fly_addr;
    logic [63:0] m_held[$];
    logic [31:0] m_pipe_pc, m_pipe_pc4, m_pipe_data;
    bit          m_pipe_valid;
    logic [31:0] m_fetch_cnt, m_flush_cnt;

    // Memory responder state.
    bit mem_busy;
    int mem_left;

    fetch_stage #(.RESET_PC(TB_RESET_PC)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .stall      (stall),
        .control_j  (control_j),
        .pc_j       (pc_j),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_data  (imem_data),
        .pipe_pc    (pipe_pc),
        .pipe_pc4   (pipe_pc4),
        .pipe_data  (pipe_data),
        .pipe_valid (pipe_valid)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        cmp_count++;
        if (observed !== expected) begin
            mism_count++;
            $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic model_reset();
        m_idle       = 1'b1;
        m_pc         = TB_RESET_PC;
        m_fly        = 1'b0;
        m_dead       = 1'b0;
        m_fly_addr   = TB_RESET_PC;
        m_held.delete();
        m_pipe_pc    = '0;
        m_pipe_pc4   = '0;
        m_pipe_data  = NOP_WORD;
        m_pipe_valid = 1'b0;
        m_fetch_cnt  = '0;
        m_flush_cnt  = '0;
        mem_busy     = 1'b0;
        mem_left     = 0;
    endtask

    task automatic model_load(input logic [31:0] pc, input logic [31:0] word);
        m_pipe_pc    = pc;
        m_pipe_pc4   = pc + 32'd4;
        m_pipe_data  = word;
        m_pipe_valid = 1'b1;
        m_fetch_cnt  = m_fetch_cnt + 32'd1;
    endtask

    task automatic model_squash();
        m_pipe_data  = NOP_WORD;
        m_pipe_valid = 1'b0;
    endtask

    // Advance the model by one clock given this cycle's inputs.
    task automatic model_step(input bit st, input bit cj, input logic [31:0] pj,
                              input bit req, input bit rdy, input logic [31:0] addr);
        logic [31:0] tgt;
        logic [63:0] entry;
        bit          acc;
        tgt = {pj[31:2], 2'b00};
        acc = req && rdy;
        if (m_idle) begin
            m_idle = 1'b0;
        end else if (m_held.size() != 0) begin
            if (cj) begin
                m_held.delete();
                m_pc = tgt;
                model_squash();
                m_flush_cnt = m_flush_cnt + 32'd1;
            end else if (!st) begin
                entry = m_held.pop_front();
                model_load(entry[63:32], entry[31:0]);
            end
        end else if (m_fly && m_dead) begin
            if (cj) begin
                m_pc = tgt;
                m_flush_cnt = m_flush_cnt + 32'd1;
            end
            if (acc) begin
                m_fly  = 1'b0;
                m_dead = 1'b0;
            end
            if (!st) model_squash();
        end else if (cj) begin
            m_flush_cnt = m_flush_cnt + 32'd1;
            m_pc = tgt;
            model_squash();
            if (req && !rdy) begin
                m_fly      = 1'b1;
                m_dead     = 1'b1;
                m_fly_addr = addr;
            end else begin
                m_fly = 1'b0;
            end
        end else if (acc) begin
            m_fly = 1'b0;
            m_pc  = addr + 32'd4;
            if (st) m_held.push_back({addr, addr ^ DATA_KEY});
            else    model_load(addr, addr ^ DATA_KEY);
        end else begin
            if (req) begin
                m_fly      = 1'b1;
                m_fly_addr = addr;
            end
            if (!st) model_squash();
        end
    endtask

    // One clock of stimulus. Entered and left 1 time unit after a rising edge.
    // lat < 0 picks a random memory latency for a newly issued request.
    task automatic applyStimulus(input bit st, input bit cj, input logic [31:0] pj, input int lat);
        bit          exp_req;
        logic [31:0] exp_addr;
        stall      = st;
        control_j  = cj;
        pc_j       = pj;
        imem_ready = 1'b0;
        imem_data  = $urandom;
        #1;
        checkOutput("pipe_pc",    pipe_pc,    m_pipe_pc);
        checkOutput("pipe_pc4",   pipe_pc4,   m_pipe_pc4);
        checkOutput("pipe_data",  pipe_data,  m_pipe_data);
        checkOutput("pipe_valid", {31'b0, pipe_valid}, {31'b0, m_pipe_valid});
`ifdef FETCH_PERF_EN
        checkOutput("perf_fetch_cnt", perf_fetch_cnt, m_fetch_cnt);
        checkOutput("perf_flush_cnt", perf_flush_cnt, m_flush_cnt);
`endif
        exp_req  = !m_idle && (m_held.size() == 0) && (m_fly || !st);
        exp_addr = m_fly ? m_fly_addr : m_pc;
        checkOutput("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
        if (exp_req || m_idle) checkOutput("imem_addr", imem_addr, exp_addr);
        if (imem_req) begin
            if (!mem_busy) begin
                mem_busy = 1'b1;
                if (lat >= 0) mem_left = lat;
                else mem_left = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 4));
            end
            if (mem_left == 0) begin
                imem_ready = 1'b1;
                imem_data  = imem_addr ^ DATA_KEY;
                mem_busy   = 1'b0;
            end else begin
                mem_left--;
            end
        end else if (m_idle && $urandom_range(0, 1) == 1) begin
            imem_ready = 1'b1;
        end
        #1;
        model_step(st, cj, pj, exp_req, imem_ready, exp_addr);
        @(posedge clk);
        #1;
    endtask

    // Assert reset in the middle of a cycle, verify the asynchronous clear,
    // then release it just after a rising edge.
    task automatic applyReset();
        @(posedge clk);
        #1;
        imem_ready = 1'b0;
        stall      = 1'b0;
        control_j  = 1'b0;
        reset_n    = 1'b0;
        #1;
        model_reset();
        checkOutput("rst_imem_req",   {31'b0, imem_req},   32'd0);
        checkOutput("rst_imem_addr",  imem_addr,           TB_RESET_PC);
        checkOutput("rst_pipe_pc",    pipe_pc,             32'd0);
        checkOutput("rst_pipe_pc4",   pipe_pc4,            32'd0);
        checkOutput("rst_pipe_data",  pipe_data,           NOP_WORD);
        checkOutput("rst_pipe_valid", {31'b0, pipe_valid}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        model_reset();
        applyReset();

        // Boot with zero-wait memory across the address wrap: FFF8, FFFC, 0, 4.
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 32'h0, 0);

        // Response for 0x8 arrives while decode is stalled for three cycles.
        applyStimulus(1'b0, 1'b0, 32'h0, 2);
        applyStimulus(1'b1, 1'b0, 32'h0, 0);
        applyStimulus(1'b1, 1'b0, 32'h0, 0);
        applyStimulus(1'b1, 1'b0, 32'h0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 32'h0, 0);

        // Redirect with zero-wait memory to an unaligned target.
        applyStimulus(1'b0, 1'b1, 32'h0000_0103, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 32'h0, 0);

        // Slow response with a redirect while the request is outstanding.
        applyStimulus(1'b0, 1'b0, 32'h0, 4);
        applyStimulus(1'b0, 1'b1, 32'h0000_0040, 0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 32'h0, 0);

        // Reset pulsed while a request is waiting on memory.
        applyStimulus(1'b0, 1'b0, 32'h0, 5);
        applyStimulus(1'b0, 1'b0, 32'h0, 0);
        applyReset();
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 32'h0, 0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 2000; i++) begin
            bit st;
            bit cj;
            st = ($urandom_range(0, 3) == 0);
            cj = ($urandom_range(0, 9) == 0) && !m_idle;
            if (i % 500 == 499) applyReset();
            else applyStimulus(st, cj, $urandom, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, mism_count);
        $finish;
    end

endmodule
